serial_add_sub: RTL and testbench

Bit-serial adder/subtractor for the arithmetic-block library. It is the sequential counterpart to the combinational half-subtractor cell. It accepts two WIDTH-bit operands through a start/ready handshake and processes one bit per clock, LSB first, through a single full-adder/full-subtractor cell with a registered carry/borrow. It returns the result plus carry-out or borrow-out with a one-cycle `done` pulse, trading latency for a single arithmetic cell.

---
 rtl/serial_add_sub.sv | 165 ++++++++++++++++
 tb/tb_serial_add_sub.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder/subtractor cell, LSB first, WIDTH cycles per operation.
// Optional signed-overflow output enabled by defining SERIAL_ADD_SUB_OVF_EN.
//
// state | meaning
// IDLE  | ready for a new operation
// RUN   | processing one operand bit per clock
// DONE  | one-cycle completion pulse, result/cout valid
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             op_q, op_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
`endif

  logic             ai, bi, s_bit, c_next;
  logic [WIDTH-1:0] acc_full;

  assign ai       = a_sh_q[0];
  assign bi       = b_sh_q[0];
  assign s_bit    = ai ^ bi ^ c_q;
  assign c_next   = op_q ? ((~ai & bi) | (c_q & ~(ai ^ bi)))
                         : ((ai & bi) | (c_q & (ai ^ bi)));
  assign acc_full = {s_bit, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    op_d     = op_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          c_d     = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = c_next;
        acc_d  = acc_full;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = acc_full;
          cout_d   = c_next;
`ifdef SERIAL_ADD_SUB_OVF_EN
          // s_bit is the result MSB on the final bit
          ovf_d = op_q ? ((a_msb_q != b_msb_q) && (s_bit != a_msb_q))
                       : ((a_msb_q == b_msb_q) && (s_bit != a_msb_q));
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN) || (state_d == DONE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      op_q     <= op_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=8) with an expected-result queue.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       ready, busy, done, cout;
  logic [7:0] result;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
  } exp_t;
  exp_t sb[$];

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result), .cout(cout)
`ifdef SERIAL_ADD_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request and push its reference result.
  task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [8:0] full;
    if (o) begin
      full = {1'b0, x} - {1'b0, y};
      e.c  = (x < y);
      e.v  = (x[7] != y[7]) && (full[7] != x[7]);
    end else begin
      full = {1'b0, x} + {1'b0, y};
      e.c  = full[8];
      e.v  = (x[7] == y[7]) && (full[7] != x[7]);
    end
    e.r = full[7:0];
    sb.push_back(e);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
  endtask

  task automatic accept(input string tag);
    check({tag, "_ready_before_accept"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for done, compare against the queue head, then check the return to IDLE.
  task automatic wait_done(input string tag, input bit disturb);
    int n = 0;
    exp_t e;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (disturb && n == 3) begin
        start = 1'b1; op = 1'b1; a = 8'hFF; b = 8'h11;
      end
      if (disturb && n == 4) start = 1'b0;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_busy_in_done"}, {30'd0, busy, ready}, 32'd2);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(result), 32'(e.r));
      check({tag, "_cout"}, 32'(cout), 32'(e.c));
`ifdef SERIAL_ADD_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(e.v));
`endif
    end
    // Start during DONE must be ignored; held high it is taken once ready returns.
    if (disturb) issue(1'b1, 8'd9, 8'd4);
    @(posedge clk);
    #1;
    check({tag, "_back_to_idle"}, {29'd0, ready, busy, done}, 32'd4);
  endtask

  initial begin
    #12;
    check("reset_state", {20'd0, ready, busy, done, cout, result}, {20'd0, 4'b1000, 8'h00});
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(1'b0, 8'd100, 8'd27);  accept("add_100_27");  wait_done("add_100_27", 1'b0);
    issue(1'b0, 8'd200, 8'd100); accept("add_200_100"); wait_done("add_200_100", 1'b0);
    issue(1'b1, 8'd5, 8'd3);     accept("sub_5_3");     wait_done("sub_5_3", 1'b0);
    issue(1'b1, 8'd3, 8'd5);     accept("sub_3_5");     wait_done("sub_3_5", 1'b0);
    issue(1'b1, 8'd0, 8'd0);     accept("sub_0_0");     wait_done("sub_0_0", 1'b0);

    issue(1'b0, 8'd50, 8'd60);   accept("add_50_60");   wait_done("add_50_60", 1'b1);
    accept("held_sub_9_4");
    wait_done("held_sub_9_4", 1'b0);

    issue(1'b0, 8'd255, 8'd1);
    accept("abort_255_1");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("abort_outputs", {20'd0, ready, busy, done, cout, result}, {20'd0, 4'b1000, 8'h00});
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(1'b0, 8'd255, 8'd1);
    accept("add_255_1");
    wait_done("add_255_1", 1'b0);

`ifdef SERIAL_ADD_SUB_OVF_EN
    issue(1'b0, 8'd100, 8'd100); accept("ovf_add_100_100"); wait_done("ovf_add_100_100", 1'b0);
    issue(1'b1, 8'h80, 8'h01);   accept("ovf_sub_80_01");   wait_done("ovf_sub_80_01", 1'b0);
    issue(1'b0, 8'd10, 8'd20);   accept("ovf_add_10_20");   wait_done("ovf_add_10_20", 1'b0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
